// File: rtl/step_motor_phase_gen.sv
// One-channel stepper phase sequencer: valid/ready move commands drive a half-step phase table.
// Optional coil release after HOLD_CYCLES idle cycles when STEP_IDLE_RELEASE_EN is defined.
module step_motor_phase_gen #(
  parameter int PERIOD_W    = 16,
  parameter int COUNT_W     = 16,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic                cmd_half,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic [COUNT_W-1:0]  cmd_steps,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                step_pulse,
  output logic [31:0]         position,
  output logic                AX,
  output logic                AY,
  output logic                BX,
  output logic                BY
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_reg, state_next;
  logic                 dir_reg, dir_next;
  logic                 half_reg, half_next;
  logic [PERIOD_W-1:0]  period_reg, period_next;
  logic [PERIOD_W-1:0]  div_reg, div_next;
  logic [COUNT_W-1:0]   remaining_reg, remaining_next;
  logic [2:0]           index_reg, index_next;
  logic [31:0]          position_reg, position_next;
  logic                 energised_reg, energised_next;
  logic                 done_reg, done_next;
  logic                 step_reg, step_next;
  logic [3:0]           phase_reg, phase_next;

  logic                 accept;
  logic                 idle_release;
  logic [PERIOD_W-1:0]  div_inc;
  logic [2:0]           step_amt;
  logic [31:0]          pos_delta;

  // Table entries packed as {AX,AY,BX,BY}, index 0 in the low nibble.
  localparam logic [31:0] PHASE_ROM = {4'b1001, 4'b0001, 4'b0101, 4'b0100,
                                       4'b0110, 4'b0010, 4'b1010, 4'b1000};
  logic [3:0] phase_table [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_table
    assign phase_table[gi] = PHASE_ROM[gi*4 +: 4];
  end

  assign accept    = cmd_valid && (state_reg == IDLE);
  assign div_inc   = div_reg + PERIOD_W'(1);
  assign step_amt  = half_reg ? 3'd1 : 3'd2;
  assign pos_delta = {29'd0, step_amt};

`ifdef STEP_IDLE_RELEASE_EN
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  logic [HOLD_W-1:0] idle_cnt_reg, idle_cnt_next;

  always_comb begin
    idle_cnt_next = '0;
    idle_release  = 1'b0;
    if (state_reg == IDLE && !accept && energised_reg) begin
      if (idle_cnt_reg == HOLD_W'(HOLD_CYCLES - 1)) begin
        idle_release = 1'b1;
      end else begin
        idle_cnt_next = idle_cnt_reg + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_cnt_reg <= '0;
    else       idle_cnt_reg <= idle_cnt_next;
  end
`else
  assign idle_release = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    dir_next       = dir_reg;
    half_next      = half_reg;
    period_next    = period_reg;
    div_next       = div_reg;
    remaining_next = remaining_reg;
    index_next     = index_reg;
    position_next  = position_reg;
    energised_next = energised_reg;
    done_next      = 1'b0;
    step_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          dir_next       = cmd_dir;
          half_next      = cmd_half;
          period_next    = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
          remaining_next = cmd_steps;
          div_next       = '0;
          energised_next = 1'b1;
          // Full-step runs on the odd (two-coil) entries only.
          if (!cmd_half) index_next = index_reg | 3'd1;
          if (cmd_steps == '0) done_next  = 1'b1;
          else                 state_next = RUN;
        end
      end
      RUN: begin
        if (remaining_reg == '0) begin
          state_next = IDLE;
        end else if (abort) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (div_inc == period_reg) begin
          div_next       = '0;
          step_next      = 1'b1;
          remaining_next = remaining_reg - COUNT_W'(1);
          index_next     = dir_reg ? index_reg + step_amt : index_reg - step_amt;
          position_next  = dir_reg ? position_reg + pos_delta : position_reg - pos_delta;
          if (remaining_reg == COUNT_W'(1)) done_next = 1'b1;
        end else begin
          div_next = div_inc;
        end
      end
      default: state_next = IDLE;
    endcase

    if (idle_release) energised_next = 1'b0;
    phase_next = energised_next ? phase_table[index_next] : 4'b0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      dir_reg       <= 1'b0;
      half_reg      <= 1'b0;
      period_reg    <= PERIOD_W'(1);
      div_reg       <= '0;
      remaining_reg <= '0;
      index_reg     <= 3'd0;
      position_reg  <= 32'd0;
      energised_reg <= 1'b0;
      done_reg      <= 1'b0;
      step_reg      <= 1'b0;
      phase_reg     <= 4'b0000;
    end else begin
      state_reg     <= state_next;
      dir_reg       <= dir_next;
      half_reg      <= half_next;
      period_reg    <= period_next;
      div_reg       <= div_next;
      remaining_reg <= remaining_next;
      index_reg     <= index_next;
      position_reg  <= position_next;
      energised_reg <= energised_next;
      done_reg      <= done_next;
      step_reg      <= step_next;
      phase_reg     <= phase_next;
    end
  end

  assign cmd_ready        = (state_reg == IDLE);
  assign busy             = (state_reg == RUN);
  assign done             = done_reg;
  assign step_pulse       = step_reg;
  assign position         = position_reg;
  assign {AX, AY, BX, BY} = phase_reg;

endmodule
